// File: rtl/serial_divider.sv
// Sequential restoring divider: 2*SIZE-bit dividend / SIZE-bit divisor, one quotient bit per clock.
// Shares the start/done handshake of the serial-parallel multiplier so it can invert its product.
module serial_divider #(
    parameter int SIZE = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2*SIZE-1:0] dividend,
    input  logic [SIZE-1:0]   divisor,
    output logic [SIZE-1:0]   q,
    output logic [SIZE-1:0]   r,
    output logic              ovf,
    output logic              busy,
    output logic              done
);

    localparam int CW = $clog2(SIZE + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [SIZE:0]     rem_reg, rem_next;
    logic [SIZE-1:0]   quo_reg, quo_next;
    logic [SIZE-1:0]   dvs_reg, dvs_next;
    logic [CW-1:0]     cnt_reg, cnt_next;
    logic [SIZE-1:0]   q_reg, q_next;
    logic [SIZE-1:0]   r_reg, r_next;
    logic              ovf_reg, ovf_next;

    logic [SIZE-1:0]   dividend_hi;
    logic [SIZE:0]     rem_shift;
    logic [SIZE:0]     trial;
    logic              trial_ok;
    logic [SIZE:0]     rem_step;
    logic [SIZE-1:0]   quo_step;

    assign dividend_hi = dividend[2*SIZE-1:SIZE];

    // The partial remainder is always below the divisor, so the shifted value fits in SIZE+1 bits.
    assign rem_shift = {rem_reg[SIZE-1:0], quo_reg[SIZE-1]};
    assign trial     = rem_shift - {1'b0, dvs_reg};
    assign trial_ok  = (rem_shift >= {1'b0, dvs_reg});
    assign rem_step  = trial_ok ? trial : rem_shift;
    assign quo_step  = {quo_reg[SIZE-2:0], trial_ok};

    always_comb begin
        state_next = state_reg;
        rem_next   = rem_reg;
        quo_next   = quo_reg;
        dvs_next   = dvs_reg;
        cnt_next   = cnt_reg;
        q_next     = q_reg;
        r_next     = r_reg;
        ovf_next   = ovf_reg;

        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    if (dividend_hi >= divisor) begin
                        // Quotient cannot fit (or divisor is zero): answer immediately.
                        state_next = DONE;
                        q_next     = '1;
                        r_next     = '0;
                        ovf_next   = 1'b1;
                    end else begin
                        state_next = RUN;
                        rem_next   = {1'b0, dividend_hi};
                        quo_next   = dividend[SIZE-1:0];
                        dvs_next   = divisor;
                        cnt_next   = CW'(SIZE);
                        q_next     = '0;
                        r_next     = '0;
                        ovf_next   = 1'b0;
                    end
                end
            end
            RUN: begin
                rem_next = rem_step;
                quo_next = quo_step;
                cnt_next = cnt_reg - CW'(1);
                if (cnt_reg == CW'(1)) begin
                    state_next = DONE;
                    q_next     = quo_step;
                    r_next     = rem_step[SIZE-1:0];
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            rem_reg   <= '0;
            quo_reg   <= '0;
            dvs_reg   <= '0;
            cnt_reg   <= '0;
            q_reg     <= '0;
            r_reg     <= '0;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            rem_reg   <= rem_next;
            quo_reg   <= quo_next;
            dvs_reg   <= dvs_next;
            cnt_reg   <= cnt_next;
            q_reg     <= q_next;
            r_reg     <= r_next;
            ovf_reg   <= ovf_next;
        end
    end

    assign q    = q_reg;
    assign r    = r_reg;
    assign ovf  = ovf_reg;
    assign busy = (state_reg == RUN);
    assign done = (state_reg == DONE);

endmodule

// File: tb/tb_serial_divider.sv
// Directed self-checking bench for serial_divider (SIZE=32): latency, overflow, protocol, reset, invariants.
module tb_serial_divider;

    localparam int SIZE = 32;

    logic              clk;
    logic              rst;
    logic              start;
    logic [2*SIZE-1:0] dividend;
    logic [SIZE-1:0]   divisor;
    logic [SIZE-1:0]   q;
    logic [SIZE-1:0]   r;
    logic              ovf;
    logic              busy;
    logic              done;

    int total = 0;
    int bad   = 0;

    serial_divider #(.SIZE(SIZE)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .q        (q),
        .r        (r),
        .ovf      (ovf),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues one operation from a posedge+1 time point and waits (bounded) for done.
    // Operands are scrambled right after the accept edge to prove they were latched.
    task automatic run_op(input logic [63:0] a, input logic [31:0] b,
                          output int cyc, output logic busy_seen, output logic both_seen);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        dividend  = {$urandom, $urandom};
        divisor   = $urandom;
        cyc       = 0;
        busy_seen = busy;
        both_seen = busy && done;
        while (!done && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            busy_seen = busy_seen | busy;
            both_seen = both_seen | (busy & done);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
        #2;
        total++;
        if ({q, r, ovf, busy, done} !== '0) begin
            bad++;
            $display("FAIL reset_async: q=%h r=%h ovf=%b busy=%b done=%b required all 0", q, r, ovf, busy, done);
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({q, r, ovf, busy, done} !== '0) begin
            bad++;
            $display("FAIL reset_release: q=%h r=%h ovf=%b busy=%b done=%b required all 0", q, r, ovf, busy, done);
        end
        $display("reset: q=%h r=%h ovf=%b busy=%b done=%b", q, r, ovf, busy, done);
    endtask

    task automatic test_basic();
        int cyc; logic bs, both;
        run_op(64'd100, 32'd7, cyc, bs, both);
        $display("basic: 100/7 -> q=%0d r=%0d ovf=%b cycles=%0d", q, r, ovf, cyc);
        total++;
        if (cyc !== 32) begin bad++; $display("FAIL basic_latency: got %0d required 32", cyc); end
        total++;
        if (q !== 32'd14 || r !== 32'd2 || ovf !== 1'b0) begin
            bad++; $display("FAIL basic_result: q=%0d r=%0d ovf=%b required q=14 r=2 ovf=0", q, r, ovf);
        end
        total++;
        if (both !== 1'b0 || bs !== 1'b1) begin
            bad++; $display("FAIL basic_busy: busy_seen=%b busy_and_done=%b required 1,0", bs, both);
        end
        @(posedge clk); #1;
        total++;
        if (done !== 1'b1 || q !== 32'd14 || r !== 32'd2) begin
            bad++; $display("FAIL basic_hold: done=%b q=%0d r=%0d required 1,14,2", done, q, r);
        end
    endtask

    task automatic test_inverse();
        int cyc; logic bs, both;
        logic [31:0] mc_tab [5] = '{32'd3, 32'h0000FFFF, 32'd12345, 32'h80000000, 32'd1};
        logic [31:0] mp_tab [5] = '{32'd5, 32'h00010001, 32'd6789, 32'd2, 32'hFFFFFFFF};
        logic [63:0] prod;
        run_op(64'hFFFFFFFE_00000001, 32'hFFFFFFFF, cyc, bs, both);
        $display("inverse: FFFFFFFE00000001/FFFFFFFF -> q=%h r=%h ovf=%b", q, r, ovf);
        total++;
        if (q !== 32'hFFFFFFFF || r !== 32'd0 || ovf !== 1'b0 || cyc !== 32) begin
            bad++; $display("FAIL inverse_max: q=%h r=%h ovf=%b cyc=%0d required FFFFFFFF 0 0 32", q, r, ovf, cyc);
        end
        for (int i = 0; i < 5; i++) begin
            prod = 64'(mc_tab[i]) * 64'(mp_tab[i]);
            run_op(prod, mc_tab[i], cyc, bs, both);
            $display("inverse: %h/%h -> q=%h r=%h", prod, mc_tab[i], q, r);
            total++;
            if (q !== mp_tab[i] || r !== 32'd0 || ovf !== 1'b0) begin
                bad++; $display("FAIL inverse_pair%0d: q=%h r=%h ovf=%b required q=%h r=0 ovf=0", i, q, r, ovf, mp_tab[i]);
            end
        end
    endtask

    task automatic test_overflow();
        int cyc; logic bs, both;
        logic [63:0] dv_tab [3] = '{64'h00000001_00000000, 64'd0, 64'h12345678_9ABCDEF0};
        logic [31:0] ds_tab [3] = '{32'd1, 32'd0, 32'd0};
        for (int i = 0; i < 3; i++) begin
            run_op(dv_tab[i], ds_tab[i], cyc, bs, both);
            $display("overflow: %h/%h -> q=%h r=%h ovf=%b cycles=%0d busy_seen=%b", dv_tab[i], ds_tab[i], q, r, ovf, cyc, bs);
            total++;
            if (cyc !== 0 || ovf !== 1'b1 || q !== 32'hFFFFFFFF || r !== 32'd0 || bs !== 1'b0) begin
                bad++;
                $display("FAIL overflow%0d: cyc=%0d ovf=%b q=%h r=%h busy_seen=%b required 0 1 FFFFFFFF 0 0",
                         i, cyc, ovf, q, r, bs);
            end
        end
    endtask

    task automatic test_protocol();
        int cyc;
        dividend = 64'd100; divisor = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        total++;
        if (busy !== 1'b1 || done !== 1'b0 || ovf !== 1'b0) begin
            bad++; $display("FAIL protocol_accept: busy=%b done=%b ovf=%b required 1 0 0", busy, done, ovf);
        end
        cyc = 0;
        while (!done && cyc < 100) begin
            if (cyc == 10) begin dividend = 64'd1000; divisor = 32'd10; start = 1'b1; end
            else start = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        $display("protocol: start during RUN -> q=%0d r=%0d cycles=%0d", q, r, cyc);
        total++;
        if (cyc !== 32 || q !== 32'd14 || r !== 32'd2) begin
            bad++; $display("FAIL protocol_ignore: cyc=%0d q=%0d r=%0d required 32 14 2", cyc, q, r);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        // Arrives here with done=1; start held high from now on.
        dividend = 64'd1000; divisor = 32'd10; start = 1'b1;
        @(posedge clk); #1;
        total++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            bad++; $display("FAIL b2b_accept: busy=%b done=%b required 1 0", busy, done);
        end
        cyc = 0;
        while (!done && cyc < 100) begin @(posedge clk); #1; cyc++; end
        $display("back_to_back: 1000/10 -> q=%0d r=%0d cycles=%0d", q, r, cyc);
        total++;
        if (cyc !== 32 || q !== 32'd100 || r !== 32'd0) begin
            bad++; $display("FAIL b2b_result: cyc=%0d q=%0d r=%0d required 32 100 0", cyc, q, r);
        end
        dividend = 64'd99; divisor = 32'd4;
        @(posedge clk); #1;
        total++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            bad++; $display("FAIL b2b_done_pulse: done=%b busy=%b required 0 1", done, busy);
        end
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < 100) begin @(posedge clk); #1; cyc++; end
        $display("back_to_back: 99/4 -> q=%0d r=%0d", q, r);
        total++;
        if (q !== 32'd24 || r !== 32'd3) begin
            bad++; $display("FAIL b2b_second: q=%0d r=%0d required 24 3", q, r);
        end
    endtask

    task automatic test_reset_mid();
        int cyc; logic bs, both;
        dividend = 64'd12345678; divisor = 32'd9; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        $display("reset_mid: q=%h r=%h ovf=%b busy=%b done=%b", q, r, ovf, busy, done);
        total++;
        if ({q, r, ovf, busy, done} !== '0) begin
            bad++; $display("FAIL reset_mid: q=%h r=%h ovf=%b busy=%b done=%b required all 0", q, r, ovf, busy, done);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        run_op(64'd1000, 32'd10, cyc, bs, both);
        $display("reset_mid: after release 1000/10 -> q=%0d r=%0d", q, r);
        total++;
        if (q !== 32'd100 || r !== 32'd0 || cyc !== 32) begin
            bad++; $display("FAIL reset_recover: q=%0d r=%0d cyc=%0d required 100 0 32", q, r, cyc);
        end
    endtask

    task automatic test_random();
        int cyc; logic bs, both;
        logic [31:0] b, hi, lo;
        logic [63:0] a, recon;
        for (int i = 0; i < 300; i++) begin
            b  = $urandom;
            if (i % 3 == 0) b = b >> (i % 31);
            if (b == 0) b = 32'd1;
            hi = $urandom % b;
            lo = $urandom;
            a  = {hi, lo};
            run_op(a, b, cyc, bs, both);
            recon = 64'(q) * 64'(b) + 64'(r);
            $display("random %0d: %h/%h -> q=%h r=%h", i, a, b, q, r);
            total++;
            if (recon !== a || r >= b || ovf !== 1'b0 || both !== 1'b0 || q !== 32'(a / 64'(b))) begin
                bad++;
                $display("FAIL random%0d: q=%h r=%h ovf=%b q*d+r=%h required dividend=%h r<%h q=%h",
                         i, q, r, ovf, recon, a, b, 32'(a / 64'(b)));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_inverse();
        test_overflow();
        test_protocol();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
